// File: rtl/hsst_sig_sync_filt_v1_1.sv
// hsst_sig_sync_filt_v1_1: multi-channel synchroniser with optional stability filter and
// registered rise/fall pulses. The filter is built only when HSST_SYNC_FILT_EN is defined.
`default_nettype none

module hsst_sig_sync_filt_v1_1 #(
   parameter int               WIDTH    = 4,
   parameter int               STAGES   = 2,
   parameter int               FILT_CNT = 8,
   parameter logic [WIDTH-1:0] RST_VAL  = {WIDTH{1'b0}}
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] sig_async,
   output logic [WIDTH-1:0] sig_synced,
   output logic [WIDTH-1:0] sig_rise,
   output logic [WIDTH-1:0] sig_fall,
   output logic             sig_any_chg
);

   logic [WIDTH-1:0] s_last;
   logic [WIDTH-1:0] upd;
   logic             any_q;

   // FILT_CNT only shapes the counter; referenced here so every build elaborates it.
   if (FILT_CNT < 1 || FILT_CNT > 255) begin : g_filt_cnt_range
   end

   for (genvar i = 0; i < WIDTH; i++) begin : g_chan
      logic [STAGES-1:0] sreg;
      logic              synced_q;
      logic              rise_q;
      logic              fall_q;

      always_ff @(posedge clk or posedge rst) begin
         if (rst) sreg <= {STAGES{RST_VAL[i]}};
         else     sreg <= {sreg[STAGES-2:0], sig_async[i]};
      end

      assign s_last[i] = sreg[STAGES-1];

`ifdef HSST_SYNC_FILT_EN
      localparam int            CW       = $clog2(FILT_CNT + 1);
      localparam logic [CW-1:0] CNT_LAST = CW'(FILT_CNT - 1);
      logic [CW-1:0]            cnt;

      assign upd[i] = (s_last[i] != synced_q) && (cnt == CNT_LAST);

      // Any return to the accepted level restarts the stability window.
      always_ff @(posedge clk or posedge rst) begin
         if (rst)                                     cnt <= '0;
         else if ((s_last[i] == synced_q) || upd[i])  cnt <= '0;
         else                                         cnt <= cnt + 1'b1;
      end
`else
      assign upd[i] = (s_last[i] != synced_q);
`endif

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            synced_q <= RST_VAL[i];
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
         end else begin
            if (upd[i]) synced_q <= s_last[i];
            rise_q <= upd[i] &  s_last[i];
            fall_q <= upd[i] & ~s_last[i];
         end
      end

      assign sig_synced[i] = synced_q;
      assign sig_rise[i]   = rise_q;
      assign sig_fall[i]   = fall_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) any_q <= 1'b0;
      else     any_q <= |upd;
   end

   assign sig_any_chg = any_q;

endmodule

`default_nettype wire

// File: tb/tb_hsst_sig_sync_filt_v1_1.sv
// Directed bench for hsst_sig_sync_filt_v1_1 (4 channels, RST_VAL=4'b1010, plus a
// 1-channel STAGES=3 transparent instance).
`default_nettype none

module tb_hsst_sig_sync_filt_v1_1;

`ifdef HSST_SYNC_FILT_EN
   localparam int EFF = 8;
`else
   localparam int EFF = 1;
`endif
   localparam int LAT = 2 + EFF;
   localparam int G7  = (7 >= EFF) ? 1 : 0;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] sig_async = 4'b1010;
   logic [3:0] sig_synced, sig_rise, sig_fall;
   logic       sig_any_chg;
   logic [0:0] b_async = 1'b0;
   logic [0:0] b_synced, b_rise, b_fall;
   logic       b_any;

   int n_vec = 0;
   int n_err = 0;

   logic [3:0] stim  [0:63];
   logic [3:0] syn_h [0:63];
   logic [3:0] ri_h  [0:63];
   logic [3:0] fa_h  [0:63];
   logic       an_h  [0:63];
   int         ncap = 0;
   logic [2:0] bh_s  [0:15];
   logic [2:0] bh_r  [0:15];
   logic [2:0] bh_f  [0:15];

   hsst_sig_sync_filt_v1_1 #(
      .WIDTH(4), .STAGES(2), .FILT_CNT(8), .RST_VAL(4'b1010)
   ) u_dut (
      .clk(clk), .rst(rst), .sig_async(sig_async), .sig_synced(sig_synced),
      .sig_rise(sig_rise), .sig_fall(sig_fall), .sig_any_chg(sig_any_chg)
   );

   hsst_sig_sync_filt_v1_1 #(
      .WIDTH(1), .STAGES(3), .FILT_CNT(1), .RST_VAL(1'b0)
   ) u_dut3 (
      .clk(clk), .rst(rst), .sig_async(b_async), .sig_synced(b_synced),
      .sig_rise(b_rise), .sig_fall(b_fall), .sig_any_chg(b_any)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic fill(input logic [3:0] v_hi, input int hi_len, input logic [3:0] v_lo);
      for (int k = 1; k < 64; k++) stim[k] = (k <= hi_len) ? v_hi : v_lo;
   endtask

   // Edge k of a run captures stim[k]; outputs are sampled 1 time unit after edge k.
   task automatic run(input int n);
      ncap = n;
      for (int k = 1; k <= n; k++) begin
         sig_async = stim[k];
         tick();
         syn_h[k] = sig_synced;
         ri_h[k]  = sig_rise;
         fa_h[k]  = sig_fall;
         an_h[k]  = sig_any_chg;
      end
   endtask

   function automatic logic getb(input int kind, input int k, input int ch);
      case (kind)
         1:       return ri_h[k][ch];
         2:       return fa_h[k][ch];
         default: return an_h[k];
      endcase
   endfunction

   function automatic int count_hi(input int kind, input int ch);
      int c = 0;
      for (int k = 1; k <= ncap; k++) if (getb(kind, k, ch)) c++;
      return c;
   endfunction

   function automatic int first_hi(input int kind, input int ch);
      for (int k = 1; k <= ncap; k++) if (getb(kind, k, ch)) return k;
      return 0;
   endfunction

   function automatic logic [3:0] or_pulses();
      logic [3:0] acc = 4'b0;
      for (int k = 1; k <= ncap; k++) acc = acc | ri_h[k] | fa_h[k];
      return acc;
   endfunction

   initial begin
      // Reset state
      tick(); tick(); tick();
      check("rst_synced", 32'(sig_synced), 32'h0000000a);
      check("rst_pulses", {sig_rise, sig_fall, 3'b0, sig_any_chg}, 32'h0);
      rst = 1'b0;
      fill(4'b1010, 0, 4'b1010);
      run(15);
      check("post_rst_no_pulse", 32'(or_pulses()), 32'h0);
      check("post_rst_no_any", 32'(count_hi(3, 0)), 32'h0);
      check("post_rst_synced", 32'(syn_h[15]), 32'h0000000a);

      // Latency of a single rising channel
      fill(4'b1011, 0, 4'b1011);
      run(20);
      check("lat_synced_before", 32'(syn_h[LAT-1][0]), 32'h0);
      check("lat_synced_at", 32'(syn_h[LAT][0]), 32'h1);
      check("lat_rise_edge", 32'(first_hi(1, 0)), 32'(LAT));
      check("lat_rise_count", 32'(count_hi(1, 0)), 32'h1);
      check("lat_any_edge", 32'(first_hi(3, 0)), 32'(LAT));
      check("lat_any_count", 32'(count_hi(3, 0)), 32'h1);
      check("lat_no_fall", 32'(count_hi(2, 0)), 32'h0);

      // Short and just-long-enough highs on channel 2
      fill(4'b1111, 7, 4'b1011);
      run(30);
      check("glitch7_rise", 32'(count_hi(1, 2)), 32'(G7));
      check("glitch7_fall", 32'(count_hi(2, 2)), 32'(G7));
      fill(4'b1111, 9, 4'b1011);
      run(30);
      check("high9_rise_edge", 32'(first_hi(1, 2)), 32'(LAT));
      check("high9_fall_edge", 32'(first_hi(2, 2)), 32'(9 + LAT));
      check("high9_rise_count", 32'(count_hi(1, 2)), 32'h1);
      check("high9_other_ch", 32'(or_pulses() & 4'b1011), 32'h0);

      // Channels 0 and 3 together: fall, then rise
      fill(4'b0010, 0, 4'b0010);
      run(15);
      check("simul_fall_vec", 32'(fa_h[LAT]), 32'h00000009);
      fill(4'b1011, 0, 4'b1011);
      run(15);
      check("simul_rise_vec", 32'(ri_h[LAT]), 32'h00000009);
      check("simul_rise_pre", 32'(ri_h[LAT-1]), 32'h0);
      check("simul_any_at", 32'(an_h[LAT]), 32'h1);
      check("simul_any_count", 32'(count_hi(3, 0)), 32'h1);

      // Reset in the middle of a filter window on channel 2
      fill(4'b1111, 0, 4'b1111);
      run(7);
      rst = 1'b1;
      #1;
      check("mid_rst_synced", 32'(sig_synced), 32'h0000000a);
      check("mid_rst_pulses", {sig_rise, sig_fall, 3'b0, sig_any_chg}, 32'h0);
      tick(); tick();
      rst = 1'b0;
      run(20);
      check("refilt_synced_pre", 32'(syn_h[LAT-1]), 32'h0000000a);
      check("refilt_synced_at", 32'(syn_h[LAT]), 32'h0000000f);
      check("refilt_rise_vec", 32'(ri_h[LAT]), 32'h00000005);
      check("refilt_rise_pre", 32'(ri_h[LAT-1]), 32'h0);
      check("refilt_no_fall", 32'(count_hi(2, 1)), 32'h0);
      check("refilt_any_count", 32'(count_hi(3, 0)), 32'h1);

      // Three-stage transparent channel: one-cycle input pulse
      for (int k = 1; k <= 8; k++) begin
         b_async = (k == 1) ? 1'b1 : 1'b0;
         tick();
         bh_s[k] = {2'b0, b_synced};
         bh_r[k] = {2'b0, b_rise};
         bh_f[k] = {2'b0, b_fall};
      end
      check("s3_synced_e3", 32'(bh_s[3]), 32'h0);
      check("s3_synced_e4", 32'(bh_s[4]), 32'h1);
      check("s3_synced_e5", 32'(bh_s[5]), 32'h0);
      check("s3_rise_e4", 32'(bh_r[4]), 32'h1);
      check("s3_fall_e5", 32'(bh_f[5]), 32'h1);
      check("s3_fall_e4", 32'(bh_f[4]), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire
